// File: rtl/shell_role_ctrl.sv
// -----------------------------------------------------------------------------
// shell_role_ctrl
//   AXI4-Lite control slave that drives an array of CHANNEL role instances:
//   per-channel start pulse, timed soft reset, sticky done status with W1C,
//   interrupt enable and a level interrupt to the PS.
//
// Ports
//   aclk, aresetn        clock and asynchronous active-low reset
//   s_axil_aw*/w*/b*     AXI4-Lite write address / data / response channels
//   s_axil_ar*/r*        AXI4-Lite read address / data channels
//   role_start[c]        one-cycle start pulse to role c
//   role_rst_n[c]        active-low soft reset to role c
//   role_done[c]         done indication from role c (rising edge detected)
//   irq                  registered OR of (status & irq_en)
//
// Register map (word offset, addr[4:2] only)
//   0x00 ID      RO  SHELL_ID
//   0x04 START   WO  bit c pulses role_start[c], sets busy[c]
//   0x08 SRST    WO  bit c restarts the soft-reset countdown of channel c
//   0x0C STATUS  W1C sticky done bits
//   0x10 IRQ_EN  RW
//   0x14 BUSY    RO
//   0x18/0x1C    SLVERR
// -----------------------------------------------------------------------------
module shell_role_ctrl #(
    parameter int          CHANNEL    = 4,
    parameter int          ADDR_WIDTH = 8,
    parameter int          RST_CYCLES = 16,
    parameter logic [31:0] SHELL_ID   = 32'h5A31_0001
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [31:0]           s_axil_wdata,
    input  logic [3:0]            s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,

    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [31:0]           s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,

    output logic [CHANNEL-1:0]    role_start,
    output logic [CHANNEL-1:0]    role_rst_n,
    input  logic [CHANNEL-1:0]    role_done,
    output logic                  irq
);

    typedef enum logic [2:0] {
        REG_ID     = 3'd0,
        REG_START  = 3'd1,
        REG_SRST   = 3'd2,
        REG_STATUS = 3'd3,
        REG_IRQ_EN = 3'd4,
        REG_BUSY   = 3'd5,
        REG_RSV6   = 3'd6,
        REG_RSV7   = 3'd7
    } reg_sel_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [7:0] RST_LOAD    = 8'(RST_CYCLES);

    // Ready outputs stay low while in reset and for the first edge after it.
    logic                 live;

    // Write channel capture
    logic                 aw_held;
    reg_sel_t             aw_sel;
    logic                 w_held;
    logic [31:0]          w_data;
    logic [3:0]           w_strb;
    logic                 bvalid_q;
    logic [1:0]           bresp_q;

    // Read channel
    logic                 rvalid_q;
    logic [1:0]           rresp_q;
    logic [31:0]          rdata_q;
    logic [31:0]          rd_word;
    logic                 rd_err;

    // Channel state
    logic [CHANNEL-1:0]   status;
    logic [CHANNEL-1:0]   irq_en;
    logic [CHANNEL-1:0]   busy;
    logic [CHANNEL-1:0]   done_q;
    logic [CHANNEL-1:0]   start_q;
    logic [CHANNEL-1:0]   rst_n_vec;
    logic [7:0]           rst_cnt [CHANNEL];

    // Write decode
    logic                 wr_fire;
    logic [CHANNEL-1:0]   lane_mask;
    logic [CHANNEL-1:0]   wr_bits;
    logic [CHANNEL-1:0]   wr_start;
    logic [CHANNEL-1:0]   wr_srst;
    logic [CHANNEL-1:0]   wr_clr;
    logic                 wr_irq_en;
    logic [1:0]           wr_resp;

    logic [CHANNEL-1:0]   done_rise;
    logic [CHANNEL-1:0]   start_ok;
    logic [CHANNEL-1:0]   status_n;
    logic [CHANNEL-1:0]   busy_n;
    logic [CHANNEL-1:0]   irq_en_n;

    logic                 unused_ok;

    assign s_axil_awready = live && !aw_held && !bvalid_q;
    assign s_axil_wready  = live && !w_held  && !bvalid_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = live && !rvalid_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rdata   = rdata_q;
    assign role_start     = start_q;
    assign role_rst_n     = rst_n_vec;

    assign unused_ok = ^{s_axil_awaddr, s_axil_araddr, w_data, w_strb};

    // -------------------------------------------------------------------------
    // Write decode: the register update fires once both halves are held.
    // -------------------------------------------------------------------------
    always_comb begin
        lane_mask = '0;
        for (int unsigned c = 0; c < CHANNEL; c++) begin
            lane_mask[c] = w_strb[c[4:3]];
        end
        wr_bits   = w_data[CHANNEL-1:0] & lane_mask;
        wr_fire   = aw_held && w_held && !bvalid_q;
        wr_start  = '0;
        wr_srst   = '0;
        wr_clr    = '0;
        wr_irq_en = 1'b0;
        wr_resp   = RESP_OKAY;
        case (aw_sel)
            REG_START:  wr_start  = wr_fire ? wr_bits : '0;
            REG_SRST:   wr_srst   = wr_fire ? wr_bits : '0;
            REG_STATUS: wr_clr    = wr_fire ? wr_bits : '0;
            REG_IRQ_EN: wr_irq_en = wr_fire;
            REG_RSV6,
            REG_RSV7:   wr_resp   = RESP_SLVERR;
            default:    ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Channel next-state. A done edge beats a same-cycle W1C; a soft reset
    // clears status/busy regardless of any edge in the same cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int unsigned c = 0; c < CHANNEL; c++) begin
            rst_n_vec[c] = (rst_cnt[c] == 8'd0);
        end
        done_rise = role_done & ~done_q & rst_n_vec;
        start_ok  = wr_start & rst_n_vec;
        status_n  = ((status & ~wr_clr) | done_rise) & ~wr_srst;
        busy_n    = (busy & ~done_rise & ~wr_srst) | start_ok;
        irq_en_n  = wr_irq_en ? ((irq_en & ~lane_mask) | (w_data[CHANNEL-1:0] & lane_mask))
                              : irq_en;
    end

    // -------------------------------------------------------------------------
    // Read mux over the current register state
    // -------------------------------------------------------------------------
    always_comb begin
        rd_word = '0;
        rd_err  = 1'b0;
        case (reg_sel_t'(s_axil_araddr[4:2]))
            REG_ID:     rd_word = SHELL_ID;
            REG_STATUS: rd_word[CHANNEL-1:0] = status;
            REG_IRQ_EN: rd_word[CHANNEL-1:0] = irq_en;
            REG_BUSY:   rd_word[CHANNEL-1:0] = busy;
            REG_RSV6,
            REG_RSV7:   rd_err = 1'b1;
            default:    ;
        endcase
    end

    // -------------------------------------------------------------------------
    // AXI handshake state
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            live     <= 1'b0;
            aw_held  <= 1'b0;
            aw_sel   <= REG_ID;
            w_held   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            live <= 1'b1;

            if (s_axil_awvalid && s_axil_awready) begin
                aw_held <= 1'b1;
                aw_sel  <= reg_sel_t'(s_axil_awaddr[4:2]);
            end
            if (s_axil_wvalid && s_axil_wready) begin
                w_held <= 1'b1;
                w_data <= s_axil_wdata;
                w_strb <= s_axil_wstrb;
            end

            if (wr_fire) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
            end else if (bvalid_q && s_axil_bready) begin
                bvalid_q <= 1'b0;
            end

            if (s_axil_arvalid && s_axil_arready) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_word;
                rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (rvalid_q && s_axil_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Channel registers and interrupt
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            status  <= '0;
            irq_en  <= '0;
            busy    <= '0;
            done_q  <= '0;
            start_q <= '0;
            irq     <= 1'b0;
        end else begin
            status  <= status_n;
            irq_en  <= irq_en_n;
            busy    <= busy_n;
            done_q  <= role_done;
            start_q <= start_ok;
            irq     <= |(status & irq_en);
        end
    end

    // Counters load on reset so every role gets a full countdown after
    // aresetn releases; an SRST write reloads even mid-countdown.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned c = 0; c < CHANNEL; c++) begin
                rst_cnt[c] <= RST_LOAD;
            end
        end else begin
            for (int unsigned c = 0; c < CHANNEL; c++) begin
                if (wr_srst[c]) begin
                    rst_cnt[c] <= RST_LOAD;
                end else if (rst_cnt[c] != 8'd0) begin
                    rst_cnt[c] <= rst_cnt[c] - 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_shell_role_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shell_role_ctrl
//   Directed bench for shell_role_ctrl with CHANNEL=4, RST_CYCLES=16.
// -----------------------------------------------------------------------------
module tb_shell_role_ctrl;

    localparam int CH = 4;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [7:0]    s_axil_awaddr = '0;
    logic          s_axil_awvalid = 1'b0;
    logic          s_axil_awready;
    logic [31:0]   s_axil_wdata = '0;
    logic [3:0]    s_axil_wstrb = '0;
    logic          s_axil_wvalid = 1'b0;
    logic          s_axil_wready;
    logic [1:0]    s_axil_bresp;
    logic          s_axil_bvalid;
    logic          s_axil_bready = 1'b0;
    logic [7:0]    s_axil_araddr = '0;
    logic          s_axil_arvalid = 1'b0;
    logic          s_axil_arready;
    logic [31:0]   s_axil_rdata;
    logic [1:0]    s_axil_rresp;
    logic          s_axil_rvalid;
    logic          s_axil_rready = 1'b0;
    logic [CH-1:0] role_start;
    logic [CH-1:0] role_rst_n;
    logic [CH-1:0] role_done = '0;
    logic          irq;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [CH-1:0] start_seen = '0;
    int            start_cycles = 0;

    logic [1:0]    resp;
    logic [31:0]   data;

    always #5 aclk = ~aclk;

    shell_role_ctrl #(
        .CHANNEL    (CH),
        .ADDR_WIDTH (8),
        .RST_CYCLES (16),
        .SHELL_ID   (32'h5A31_0001)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .role_start     (role_start),
        .role_rst_n     (role_rst_n),
        .role_done      (role_done),
        .irq            (irq)
    );

    // Pulse monitor: which start bits fired and for how many cycles in total.
    always @(negedge aclk) begin
        if (role_start !== '0) begin
            start_seen   <= start_seen | role_start;
            start_cycles <= start_cycles + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // lead > 0: W follows AW by lead cycles; lead < 0: AW follows W.
    task automatic axil_write(input logic [7:0] addr, input logic [31:0] wd,
                              input logic [3:0] strb, input int lead, input int hold,
                              output logic [1:0] bresp_o);
        int   cyc;
        int   aw_start;
        int   w_start;
        logic aw_done;
        logic w_done;
        logic aw_hs;
        logic w_hs;
        logic ok;
        logic [1:0] b0;
        aw_start = (lead < 0) ? -lead : 0;
        w_start  = (lead > 0) ? lead : 0;
        aw_done  = 1'b0;
        w_done   = 1'b0;
        cyc      = 0;
        @(negedge aclk);
        s_axil_awaddr = addr;
        s_axil_wdata  = wd;
        s_axil_wstrb  = strb;
        while (!(aw_done && w_done) && cyc < 20) begin
            if (!aw_done && cyc >= aw_start) s_axil_awvalid = 1'b1;
            if (!w_done && cyc >= w_start)   s_axil_wvalid  = 1'b1;
            aw_hs = s_axil_awvalid && s_axil_awready;
            w_hs  = s_axil_wvalid && s_axil_wready;
            @(posedge aclk);
            @(negedge aclk);
            cyc++;
            if (aw_hs) begin s_axil_awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin s_axil_wvalid  = 1'b0; w_done  = 1'b1; end
        end
        while (!s_axil_bvalid && cyc < 20) begin
            @(negedge aclk);
            cyc++;
        end
        check("wr_timeout", {31'b0, (cyc >= 20)}, 32'd0);
        bresp_o = s_axil_bresp;
        b0      = s_axil_bresp;
        ok      = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            ok = ok && (s_axil_bvalid === 1'b1) && (s_axil_bresp === b0) &&
                 (s_axil_awready === 1'b0) && (s_axil_wready === 1'b0);
        end
        if (hold > 0) check("b_hold_stable", {31'b0, ok}, 32'd1);
        s_axil_bready = 1'b1;
        @(negedge aclk);
        s_axil_bready  = 1'b0;
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
    endtask

    task automatic axil_read(input logic [7:0] addr, input int hold,
                             output logic [31:0] rd_o, output logic [1:0] rresp_o);
        int   cyc;
        logic ok;
        logic [31:0] d0;
        logic [1:0]  r0;
        cyc = 0;
        @(negedge aclk);
        s_axil_araddr  = addr;
        s_axil_arvalid = 1'b1;
        while (!s_axil_arready && cyc < 20) begin
            @(negedge aclk);
            cyc++;
        end
        @(posedge aclk);
        @(negedge aclk);
        s_axil_arvalid = 1'b0;
        while (!s_axil_rvalid && cyc < 20) begin
            @(negedge aclk);
            cyc++;
        end
        check("rd_timeout", {31'b0, (cyc >= 20)}, 32'd0);
        rd_o    = s_axil_rdata;
        rresp_o = s_axil_rresp;
        d0      = s_axil_rdata;
        r0      = s_axil_rresp;
        ok      = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            ok = ok && (s_axil_rvalid === 1'b1) && (s_axil_rdata === d0) &&
                 (s_axil_rresp === r0) && (s_axil_arready === 1'b0);
        end
        if (hold > 0) check("r_hold_stable", {31'b0, ok}, 32'd1);
        s_axil_rready = 1'b1;
        @(negedge aclk);
        s_axil_rready = 1'b0;
    endtask

    initial begin
        // ---- reset state ----
        repeat (3) @(negedge aclk);
        check("rst_role_rst_n", {28'b0, role_rst_n}, 32'h0);
        check("rst_role_start", {28'b0, role_start}, 32'h0);
        check("rst_readies", {28'b0, s_axil_awready, s_axil_wready, s_axil_arready, irq}, 32'h0);
        check("rst_valids", {30'b0, s_axil_bvalid, s_axil_rvalid}, 32'h0);
        check("rst_rdata", s_axil_rdata, 32'h0);

        // ---- post-reset countdown: 16 cycles low ----
        aresetn = 1'b1;
        repeat (15) @(negedge aclk);
        check("boot_rst_n_c15", {28'b0, role_rst_n}, 32'h0);
        @(negedge aclk);
        check("boot_rst_n_c16", {28'b0, role_rst_n}, 32'hF);

        // ---- ID read, payload held 3 cycles ----
        axil_read(8'h00, 3, data, resp);
        check("id_rdata", data, 32'h5A31_0001);
        check("id_rresp", {30'b0, resp}, 32'd0);

        // ---- START=0x5, AW one cycle before W ----
        start_seen   = '0;
        start_cycles = 0;
        axil_write(8'h04, 32'h5, 4'hF, 1, 0, resp);
        @(negedge aclk);
        check("start_bresp", {30'b0, resp}, 32'd0);
        check("start_bits", {28'b0, start_seen}, 32'h5);
        check("start_one_cycle", start_cycles, 32'd1);
        axil_read(8'h14, 0, data, resp);
        check("busy_after_start", data, 32'h5);

        // ---- done on channel 0 with irq enabled ----
        axil_write(8'h10, 32'h1, 4'hF, 0, 0, resp);
        @(negedge aclk);
        role_done[0] = 1'b1;
        @(negedge aclk);
        role_done[0] = 1'b0;
        @(negedge aclk);
        check("irq_after_done", {31'b0, irq}, 32'd1);
        axil_read(8'h0C, 0, data, resp);
        check("status_after_done", data, 32'h1);
        axil_read(8'h14, 0, data, resp);
        check("busy_after_done", data, 32'h4);

        // ---- W1C clears status and irq ----
        axil_write(8'h0C, 32'h1, 4'hF, 0, 0, resp);
        check("irq_after_w1c", {31'b0, irq}, 32'd0);
        axil_read(8'h0C, 0, data, resp);
        check("status_after_w1c", data, 32'h0);

        // ---- W1C in the same cycle as a fresh done edge: set wins ----
        fork
            axil_write(8'h0C, 32'h1, 4'hF, 0, 0, resp);
            begin
                @(negedge aclk);
                @(negedge aclk);
                role_done[0] = 1'b1;
                @(negedge aclk);
                role_done[0] = 1'b0;
            end
        join
        axil_read(8'h0C, 0, data, resp);
        check("status_set_wins", data, 32'h1);
        check("irq_set_wins", {31'b0, irq}, 32'd1);
        axil_write(8'h0C, 32'h1, 4'hF, 0, 0, resp);

        // ---- soft reset on channel 1 ----
        axil_write(8'h04, 32'h2, 4'hF, 0, 0, resp);
        axil_read(8'h14, 0, data, resp);
        check("busy_before_srst", data, 32'h6);
        axil_write(8'h08, 32'h2, 4'hF, 0, 0, resp);
        check("srst_rst_n", {28'b0, role_rst_n}, 32'hD);
        axil_read(8'h14, 0, data, resp);
        check("busy_after_srst", data, 32'h4);
        start_seen   = '0;
        start_cycles = 0;
        axil_write(8'h04, 32'h2, 4'hF, 0, 0, resp);
        @(negedge aclk);
        check("start_in_reset_ignored", start_cycles, 32'd0);
        axil_read(8'h14, 0, data, resp);
        check("busy_in_reset_unchanged", data, 32'h4);
        // Reload mid-countdown; return is one edge past the reload.
        axil_write(8'h08, 32'h2, 4'hF, 0, 0, resp);
        repeat (14) @(negedge aclk);
        check("srst_reload_c15", {28'b0, role_rst_n}, 32'hD);
        @(negedge aclk);
        check("srst_reload_c16", {28'b0, role_rst_n}, 32'hF);

        // ---- unmapped offsets with stalled response ----
        axil_read(8'h1C, 10, data, resp);
        check("bad_rresp", {30'b0, resp}, 32'h2);
        check("bad_rdata", data, 32'h0);
        axil_write(8'h18, 32'hFFFF_FFFF, 4'hF, 0, 10, resp);
        check("bad_bresp", {30'b0, resp}, 32'h2);
        axil_read(8'h10, 0, data, resp);
        check("irq_en_unchanged", data, 32'h1);
        axil_read(8'h14, 0, data, resp);
        check("busy_unchanged", data, 32'h4);
        axil_read(8'h0C, 0, data, resp);
        check("status_unchanged", data, 32'h0);

        // ---- byte strobes on IRQ_EN, W ahead of AW ----
        axil_write(8'h10, 32'h0, 4'hF, -1, 0, resp);
        check("w_first_bresp", {30'b0, resp}, 32'd0);
        axil_write(8'h10, 32'hFFFF_FFFF, 4'b0010, 0, 0, resp);
        axil_read(8'h10, 0, data, resp);
        check("irq_en_lane1", data, 32'h0);
        axil_write(8'h10, 32'hFFFF_FFFF, 4'b0001, 0, 0, resp);
        axil_read(8'h10, 0, data, resp);
        check("irq_en_lane0", data, 32'hF);
        check("irq_no_status", {31'b0, irq}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shell_role_ctrl.md
Name: shell_role_ctrl

Overview:
- AXI4-Lite control slave between the PS general-purpose master port and a parametrised array of CHANNEL role instances.
- Per role: start pulse, timed soft reset, sticky done status and a maskable interrupt. Replaces hand-wired role control in the shell top.
- Sits in the shell alongside the PS block; one instance drives all role channels.

Parameters:
CHANNEL, 4, number of role channels (1..32); one register bit per channel.
ADDR_WIDTH, 8, AXI4-Lite byte address width; only addr[4:2] decoded.
RST_CYCLES, 16, cycles role_rst_n[c] is held low per soft reset (2..255).
SHELL_ID, 32'h5A31_0001, constant returned by the ID register.

Ports:
aclk  in  1  system clock (PS FCLK domain)
aresetn  in  1  asynchronous active-low reset
s_axil_awaddr  in  ADDR_WIDTH  write address
s_axil_awvalid  in  1  write address valid
s_axil_awready  out  1  write address ready
s_axil_wdata  in  32  write data
s_axil_wstrb  in  4  write byte strobes
s_axil_wvalid  in  1  write data valid
s_axil_wready  out  1  write data ready
s_axil_bresp  out  2  write response
s_axil_bvalid  out  1  write response valid
s_axil_bready  in  1  write response ready
s_axil_araddr  in  ADDR_WIDTH  read address
s_axil_arvalid  in  1  read address valid
s_axil_arready  out  1  read address ready
s_axil_rdata  out  32  read data
s_axil_rresp  out  2  read response
s_axil_rvalid  out  1  read data valid
s_axil_rready  in  1  read data ready
role_start  out  CHANNEL  one-cycle start pulse per role
role_rst_n  out  CHANNEL  active-low soft reset per role
role_done  in  CHANNEL  done pulse/level from each role (rising edge detected)
irq  out  1  level interrupt to PS

Behaviour:
- Reset (aresetn low, async): all ready/valid low, bresp/rresp/rdata 0, role_start 0, role_rst_n all 0 (roles held in reset), status/irq_en/busy 0, irq 0. Once aresetn deasserts, each channel runs a RST_CYCLES reset sequence, then role_rst_n[c]=1.
- Register map (word offsets):
  - 0x00 ID: RO, returns SHELL_ID.
  - 0x04 START: WO, bit c=1 pulses role_start[c] and sets busy[c].
  - 0x08 SRST: WO, bit c=1 starts the soft reset of channel c.
  - 0x0C STATUS: sticky done bits, W1C.
  - 0x10 IRQ_EN: RW.
  - 0x14 BUSY: RO.
  - Bits >= CHANNEL read 0 and ignore writes.
  - Any other offset: write ignored with bresp=SLVERR(2'b10); read returns rdata=0 with rresp=SLVERR.
- Write channel:
  - AW and W accepted independently, in either order or the same cycle; each ready is high while its half is not yet captured and bvalid is low.
  - The register update occurs the cycle after both halves are held; bvalid asserts the same cycle and holds until bready. One write outstanding at a time.
  - wstrb gates bytes: START/SRST/STATUS/IRQ_EN bits act only where the byte lane is enabled.
- Read channel:
  - arready high while rvalid low.
  - rvalid asserts the cycle after the AR handshake, with rdata/rresp registered. Both hold stable until rready.
  - Reads have no side effects.
- Start:
  - role_start[c] high exactly one cycle, 2 cycles after the W handshake (when AW is not later).
  - Start to a channel with role_rst_n[c]=0 is ignored: no pulse, busy unchanged.
  - Start while busy[c]=1 re-pulses; busy stays 1.
- Soft reset:
  - Per-channel down-counter loaded with RST_CYCLES; role_rst_n[c]=0 while count != 0.
  - A new SRST during countdown reloads the counter.
  - SRST clears busy[c] and status[c].
- Done:
  - A rising edge on role_done[c] (registered previous value) while role_rst_n[c]=1 sets status[c] and clears busy[c]. Edges while in reset are ignored.
  - Same-cycle set and W1C on the same bit: set wins.
- irq: registered OR of (status & irq_en). Updates one cycle after status or irq_en changes.
- Reset mid-transaction: any handshake state is dropped; the master must re-issue.

Test Plan:
- Release aresetn -> role_rst_n=0 for 16 cycles then 4'hF. Read 0x00 -> rdata=32'h5A31_0001, rresp=0.
- Write 0x04=0x5 with AW one cycle before W -> bresp=0; role_start=4'b0101 for exactly one cycle; BUSY read=0x5.
- IRQ_EN=0x1, then pulse role_done[0] -> STATUS=0x1, BUSY=0x4, irq=1. W1C 0x1 to 0x0C -> irq=0. Same test with W1C coinciding with a new done edge -> STATUS stays 0x1.
- Write SRST=0x2; at count 5, write SRST=0x2 again -> role_rst_n[1] low for 5+16 cycles total. START=0x2 during this window -> no pulse.
- Read 0x1C and write 0x18 -> rresp=SLVERR, rdata=0, bresp=SLVERR; no register changes. Hold bready/rready low 10 cycles -> bvalid/rvalid and their payloads stable, awready/arready low.
- Write IRQ_EN=0xFFFF_FFFF with wstrb=4'b0010 -> IRQ_EN reads 0 (lanes above CHANNEL bits unused). With wstrb=4'b0001 -> reads 0xF.
